// File: rtl/decode_scoreboard.sv
// Decode stage with a single instruction slot and a per-register
// pending-write scoreboard. An instruction is held in the slot until none of
// its source registers has an outstanding write. It is also held if its
// destination counter is already saturated.
module decode_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int RAW      = 5,
    parameter int PEND_W   = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_insn,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [RAW-1:0]  wb_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_insn,
    output logic [XLEN-1:0] out_pc,
    output logic [RAW-1:0]  out_rd,
    output logic            out_we,
    output logic [31:0]     stall_cnt
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_REGIMM   = 6'b000001;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_BLEZ     = 6'b000110;
    localparam logic [5:0] OP_BGTZ     = 6'b000111;
    localparam logic [5:0] OP_ADDIU    = 6'b001001;
    localparam logic [5:0] OP_SLTI     = 6'b001010;
    localparam logic [5:0] OP_ORI      = 6'b001101;
    localparam logic [5:0] OP_LUI      = 6'b001111;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_LB       = 6'b100000;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_LBU      = 6'b100100;
    localparam logic [5:0] OP_SB       = 6'b101000;
    localparam logic [5:0] OP_SW       = 6'b101011;
    localparam logic [5:0] FN_JR       = 6'b001000;

    logic              slot_valid_q, slot_valid_d;
    logic [XLEN-1:0]   slot_insn_q, slot_insn_d;
    logic [XLEN-1:0]   slot_pc_q, slot_pc_d;
    logic [PEND_W-1:0] pend_q [NUM_REGS];
    logic [PEND_W-1:0] pend_d [NUM_REGS];
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    logic [5:0]     opcode;
    logic [5:0]     funct;
    logic [RAW-1:0] rs;
    logic [RAW-1:0] rt;
    logic [RAW-1:0] rd_field;
    logic [RAW-1:0] dest;
    logic           use_rs;
    logic           use_rt;
    logic           dec_we;
    logic           write_en;
    logic           hazard;
    logic           issue;

    // Work out which source registers the held instruction reads and
    // which register it writes.
    always_comb begin
        opcode   = slot_insn_q[31:26];
        funct    = slot_insn_q[5:0];
        rs       = RAW'(slot_insn_q[25:21]);
        rt       = RAW'(slot_insn_q[20:16]);
        rd_field = RAW'(slot_insn_q[15:11]);
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        dec_we   = 1'b0;
        dest     = '0;
        case (opcode)
            OP_SPECIAL: begin
                use_rs = 1'b1;
                if (funct != FN_JR) begin
                    use_rt = 1'b1;
                    dec_we = 1'b1;
                    dest   = rd_field;
                end
            end
            OP_SPECIAL2: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                dec_we = 1'b1;
                dest   = rd_field;
            end
            OP_SW, OP_SB, OP_BEQ, OP_BNE: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_REGIMM, OP_BLEZ, OP_BGTZ: begin
                use_rs = 1'b1;
            end
            OP_LW, OP_LB, OP_LBU, OP_ADDIU, OP_SLTI, OP_ORI: begin
                use_rs = 1'b1;
                dec_we = 1'b1;
                dest   = rt;
            end
            OP_LUI: begin
                dec_we = 1'b1;
                dest   = rt;
            end
            OP_JAL: begin
                dec_we = 1'b1;
                dest   = RAW'(31);
            end
            default: begin
            end
        endcase
    end

    // Hazard detection and the handshakes on both sides of the slot.
    // A flush blocks issue, so an occupied slot cannot accept a new
    // instruction while a flush is active.
    always_comb begin
        write_en  = slot_valid_q && dec_we && (dest != '0);
        hazard    = (use_rs && (pend_q[rs] != '0))
                 || (use_rt && (pend_q[rt] != '0))
                 || (write_en && (pend_q[dest] == PEND_MAX));
        out_valid = slot_valid_q && !hazard && !flush;
        issue     = out_valid && out_ready;
        in_ready  = !slot_valid_q || issue;
        out_we    = write_en;
        out_rd    = dest;
        out_insn  = slot_insn_q;
        out_pc    = slot_pc_q;
        stall_cnt = stall_cnt_q;
    end

    // Slot contents: a flush wins and discards anything fetched in the same cycle.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_insn_d  = slot_insn_q;
        slot_pc_d    = slot_pc_q;
        if (flush) begin
            slot_valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            slot_valid_d = 1'b1;
            slot_insn_d  = in_insn;
            slot_pc_d    = in_pc;
        end else if (issue) begin
            slot_valid_d = 1'b0;
        end
    end

    // Pending counters: issue increments and retirement decrements.
    // When both hit one register, the counter is left alone.
    always_comb begin
        pend_d    = pend_q;
        pend_d[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (issue && write_en && (dest == RAW'(i))
                && !(wb_valid && (wb_rd == RAW'(i)))) begin
                pend_d[i] = pend_q[i] + PEND_W'(1);
            end else if (wb_valid && (wb_rd == RAW'(i)) && (pend_q[i] != '0)
                && !(issue && write_en && (dest == RAW'(i)))) begin
                pend_d[i] = pend_q[i] - PEND_W'(1);
            end
        end
    end

    // Count the cycles in which a held instruction is blocked by a hazard.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (slot_valid_q && hazard && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State registers; reset empties the slot and forgets all pending writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_valid_q <= 1'b0;
            slot_insn_q  <= '0;
            slot_pc_q    <= '0;
            stall_cnt_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_insn_q  <= slot_insn_d;
            slot_pc_q    <= slot_pc_d;
            stall_cnt_q  <= stall_cnt_d;
            pend_q       <= pend_d;
        end
    end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Self-checking bench for decode_scoreboard. Directed scenarios check
// against constants. A randomized run checks against a reference model.
// That model tracks pending writes as plain integer counts and keeps
// issued destinations in a queue of outstanding retirements.
module tb_decode_scoreboard;

    localparam int PEND_MAX = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_insn;
    logic [31:0] in_pc;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic        out_we;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    bit          m_valid;
    logic [31:0] m_insn;
    logic [31:0] m_pc;
    int          m_pend [32];
    int unsigned m_stall;
    int          retire_q [$];

    bit exp_out_valid;
    bit exp_in_ready;
    bit exp_we;
    bit exp_hazard;
    int exp_rd;

    logic [5:0] op_table [0:19] = '{6'b000000, 6'b000000, 6'b011100, 6'b101011, 6'b101000,
                                    6'b000100, 6'b000101, 6'b000001, 6'b100011, 6'b100000,
                                    6'b100100, 6'b000110, 6'b000111, 6'b001001, 6'b001010,
                                    6'b001101, 6'b000010, 6'b000011, 6'b001111, 6'b111111};

    decode_scoreboard dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
        .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_pc(out_pc),
        .out_rd(out_rd), .out_we(out_we), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h0042};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        w = $urandom();
        w[31:26] = op_table[$urandom_range(0, 19)];
        w[25:21] = 5'($urandom_range(0, 7));
        w[20:16] = 5'($urandom_range(0, 7));
        w[15:11] = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) w[5:0] = 6'b001000;
        return w;
    endfunction

    // Sources used and register written (0 = none), by opcode class.
    function automatic void spec_decode(input logic [31:0] insn, output bit urs, output bit urt, output int dst);
        logic [5:0] op;
        op  = insn[31:26];
        urs = 1'b0;
        urt = 1'b0;
        dst = 0;
        if (op == 6'b000000) begin
            urs = 1'b1;
            if (insn[5:0] != 6'b001000) begin
                urt = 1'b1;
                dst = int'(insn[15:11]);
            end
        end else if (op == 6'b011100) begin
            urs = 1'b1; urt = 1'b1; dst = int'(insn[15:11]);
        end else if (op inside {6'b101011, 6'b101000, 6'b000100, 6'b000101}) begin
            urs = 1'b1; urt = 1'b1;
        end else if (op inside {6'b000001, 6'b000110, 6'b000111}) begin
            urs = 1'b1;
        end else if (op inside {6'b100011, 6'b100000, 6'b100100, 6'b001001, 6'b001010, 6'b001101}) begin
            urs = 1'b1; dst = int'(insn[20:16]);
        end else if (op == 6'b001111) begin
            dst = int'(insn[20:16]);
        end else if (op == 6'b000011) begin
            dst = 31;
        end
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_insn  = '0;
        m_pc    = '0;
        m_stall = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
        retire_q.delete();
    endtask

    task automatic model_outputs();
        bit urs, urt;
        int dst;
        exp_hazard = 1'b0;
        exp_we     = 1'b0;
        exp_rd     = 0;
        if (m_valid) begin
            spec_decode(m_insn, urs, urt, dst);
            exp_we = (dst != 0);
            exp_rd = dst;
            if (urs && m_pend[int'(m_insn[25:21])] > 0) exp_hazard = 1'b1;
            if (urt && m_pend[int'(m_insn[20:16])] > 0) exp_hazard = 1'b1;
            if (exp_we && m_pend[dst] == PEND_MAX) exp_hazard = 1'b1;
        end
        exp_out_valid = m_valid && !exp_hazard && !flush;
        exp_in_ready  = !m_valid || (exp_out_valid && out_ready);
    endtask

    task automatic model_clock();
        bit issue;
        issue = exp_out_valid && out_ready;
        if (issue && exp_we) begin
            m_pend[exp_rd] = m_pend[exp_rd] + 1;
            retire_q.push_back(exp_rd);
        end
        if (wb_valid && wb_rd != 5'd0 && m_pend[int'(wb_rd)] > 0) m_pend[int'(wb_rd)] = m_pend[int'(wb_rd)] - 1;
        if (m_valid && exp_hazard && !flush && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (flush) m_valid = 1'b0;
        else if (in_valid && exp_in_ready) begin
            m_valid = 1'b1;
            m_insn  = in_insn;
            m_pc    = in_pc;
        end else if (issue) m_valid = 1'b0;
    endtask

    task automatic drive(input bit iv, input logic [31:0] insn, input logic [31:0] pc, input bit fl,
                         input bit wv, input logic [4:0] wr, input bit ordy);
        @(negedge clock);
        in_valid = iv; in_insn = insn; in_pc = pc; flush = fl;
        wb_valid = wv; wb_rd = wr; out_ready = ordy;
        if (wv) begin
            for (int k = 0; k < retire_q.size(); k++) begin
                if (retire_q[k] == int'(wr)) begin
                    retire_q.delete(k);
                    break;
                end
            end
        end
        #1;
        model_outputs();
    endtask

    task automatic tick();
        @(posedge clock);
        model_clock();
    endtask

    task automatic do_reset();
        in_valid = 0; in_insn = '0; in_pc = '0; flush = 0; wb_valid = 0; wb_rd = '0; out_ready = 1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        in_valid = 0; in_insn = '0; in_pc = '0; flush = 0; wb_valid = 0; wb_rd = '0; out_ready = 1;
        reset = 1'b1;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b expected 1", in_ready); end
        checks++; if (out_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_we got %0b expected 0", out_we); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_stall_cnt got %0d expected 0", stall_cnt); end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_raw_hazard();
        logic [31:0] a, b;
        do_reset();
        a = enc_i(6'b001001, 5'd0, 5'd8);
        b = enc_r(5'd8, 5'd0, 5'd10, 6'b100001);
        drive(1, a, 32'h100, 0, 0, 0, 1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL raw_ready_empty got %0b expected 1", in_ready); end
        tick();
        drive(1, b, 32'h104, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b1 || out_we !== 1'b1 || out_rd !== 5'd8) begin errors++; $display("[TB] FAIL raw_first_issue got v=%0b we=%0b rd=%0d expected v=1 we=1 rd=8", out_valid, out_we, out_rd); end
        tick();
        drive(0, '0, '0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL raw_held got v=%0b rdy=%0b expected v=0 rdy=0", out_valid, in_ready); end
        tick();
        drive(0, '0, '0, 0, 0, 0, 1);
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("[TB] FAIL raw_stall1 got %0d expected 1", stall_cnt); end
        tick();
        drive(0, '0, '0, 0, 1, 5'd8, 1);
        checks++; if (out_valid !== 1'b0 || stall_cnt !== 32'd2) begin errors++; $display("[TB] FAIL raw_wb_cycle got v=%0b stall=%0d expected v=0 stall=2", out_valid, stall_cnt); end
        tick();
        drive(0, '0, '0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b1 || out_insn !== b || out_pc !== 32'h104) begin errors++; $display("[TB] FAIL raw_release got v=%0b insn=%0h pc=%0h expected v=1 insn=%0h pc=104", out_valid, out_insn, out_pc, b); end
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("[TB] FAIL raw_stall_final got %0d expected 3", stall_cnt); end
        tick();
    endtask

    task automatic test_saturation();
        logic [31:0] w;
        do_reset();
        w = enc_i(6'b001001, 5'd0, 5'd5);
        for (int k = 0; k < 4; k++) begin
            drive(1, w, 32'h200 + 32'(k * 4), 0, 0, 0, 1);
            if (k > 0) begin
                checks++; if (out_valid !== 1'b1 || out_rd !== 5'd5) begin errors++; $display("[TB] FAIL sat_issue%0d got v=%0b rd=%0d expected v=1 rd=5", k, out_valid, out_rd); end
            end
            tick();
        end
        drive(0, '0, '0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL sat_fourth_held got v=%0b rdy=%0b expected v=0 rdy=0", out_valid, in_ready); end
        tick();
        drive(0, '0, '0, 0, 1, 5'd5, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL sat_wb_cycle got %0b expected 0", out_valid); end
        tick();
        drive(0, '0, '0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd5 || stall_cnt !== 32'd2) begin errors++; $display("[TB] FAIL sat_release got v=%0b rd=%0d stall=%0d expected v=1 rd=5 stall=2", out_valid, out_rd, stall_cnt); end
        tick();
    endtask

    task automatic test_same_cycle();
        logic [31:0] w, r;
        do_reset();
        w = enc_i(6'b001001, 5'd0, 5'd9);
        r = enc_r(5'd9, 5'd0, 5'd11, 6'b100001);
        drive(1, w, 32'h300, 0, 0, 0, 1);
        tick();
        drive(1, w, 32'h304, 0, 0, 0, 1);
        tick();
        drive(1, r, 32'h308, 0, 1, 5'd9, 1);
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd9) begin errors++; $display("[TB] FAIL same_issue got v=%0b rd=%0d expected v=1 rd=9", out_valid, out_rd); end
        tick();
        drive(0, '0, '0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL same_count_kept got %0b expected 0", out_valid); end
        tick();
        drive(0, '0, '0, 0, 1, 5'd9, 1);
        tick();
        drive(0, '0, '0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b1 || out_insn !== r) begin errors++; $display("[TB] FAIL same_one_wb got v=%0b insn=%0h expected v=1 insn=%0h", out_valid, out_insn, r); end
        tick();
    endtask

    task automatic test_flush();
        logic [31:0] a, beq, r0, r4;
        do_reset();
        a   = enc_i(6'b001001, 5'd0, 5'd4);
        beq = enc_i(6'b000100, 5'd4, 5'd0);
        r0  = enc_r(5'd0, 5'd0, 5'd3, 6'b100001);
        r4  = enc_r(5'd4, 5'd0, 5'd3, 6'b100001);
        drive(1, a, 32'h400, 0, 0, 0, 1);
        tick();
        drive(1, beq, 32'h404, 0, 0, 0, 1);
        tick();
        drive(0, '0, '0, 0, 0, 0, 1);
        tick();
        drive(0, '0, '0, 1, 0, 0, 1);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy got v=%0b rdy=%0b expected v=0 rdy=0", out_valid, in_ready); end
        tick();
        drive(0, '0, '0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 32'd1) begin errors++; $display("[TB] FAIL flush_cleared got v=%0b rdy=%0b stall=%0d expected v=0 rdy=1 stall=1", out_valid, in_ready, stall_cnt); end
        tick();
        drive(1, r0, 32'h408, 1, 0, 0, 1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_empty_ready got %0b expected 1", in_ready); end
        tick();
        drive(0, '0, '0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_load_discard got %0b expected 0", out_valid); end
        tick();
        drive(1, r4, 32'h40c, 0, 0, 0, 1);
        tick();
        drive(0, '0, '0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_counter_kept got %0b expected 0", out_valid); end
        tick();
        drive(0, '0, '0, 0, 1, 5'd4, 1);
        tick();
        drive(0, '0, '0, 1, 0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_masks_valid got %0b expected 0", out_valid); end
        tick();
    endtask

    task automatic test_back_pressure();
        logic [31:0] x, y;
        do_reset();
        x = enc_r(5'd1, 5'd2, 5'd3, 6'b100001);
        y = enc_r(5'd2, 5'd3, 5'd4, 6'b100001);
        drive(1, x, 32'h500, 0, 0, 0, 1);
        tick();
        drive(1, y, 32'h504, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_block got v=%0b rdy=%0b expected v=1 rdy=0", out_valid, in_ready); end
        tick();
        drive(1, y, 32'h504, 0, 0, 0, 0);
        checks++; if (out_insn !== x || out_pc !== 32'h500) begin errors++; $display("[TB] FAIL bp_stable got insn=%0h pc=%0h expected insn=%0h pc=500", out_insn, out_pc, x); end
        tick();
        drive(0, '0, '0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_insn !== x) begin errors++; $display("[TB] FAIL bp_release got v=%0b rdy=%0b insn=%0h expected v=1 rdy=1 insn=%0h", out_valid, in_ready, out_insn, x); end
        tick();
        drive(0, '0, '0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_ignored_input got %0b expected 0", out_valid); end
        tick();
    endtask

    task automatic test_zero_reg();
        logic [31:0] z, rz, p, j, lui, rs6;
        do_reset();
        z   = enc_r(5'd1, 5'd2, 5'd0, 6'b100001);
        rz  = enc_r(5'd0, 5'd0, 5'd5, 6'b100001);
        p   = enc_i(6'b001001, 5'd0, 5'd6);
        j   = {6'b000010, 5'd6, 5'd6, 16'h0000};
        lui = {6'b001111, 5'd6, 5'd7, 16'h1234};
        rs6 = enc_r(5'd6, 5'd0, 5'd8, 6'b100001);
        drive(1, z, 32'h600, 0, 0, 0, 1);
        tick();
        drive(1, z, 32'h604, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b1 || out_we !== 1'b0) begin errors++; $display("[TB] FAIL zero_write_we got v=%0b we=%0b expected v=1 we=0", out_valid, out_we); end
        tick();
        drive(1, rz, 32'h608, 0, 0, 0, 1);
        tick();
        drive(1, p, 32'h60c, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b1 || stall_cnt !== 32'd0) begin errors++; $display("[TB] FAIL zero_read got v=%0b stall=%0d expected v=1 stall=0", out_valid, stall_cnt); end
        tick();
        drive(1, j, 32'h610, 0, 0, 0, 1);
        tick();
        drive(1, lui, 32'h614, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b1 || out_we !== 1'b0) begin errors++; $display("[TB] FAIL jump_no_src got v=%0b we=%0b expected v=1 we=0", out_valid, out_we); end
        tick();
        drive(1, rs6, 32'h618, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b1 || out_we !== 1'b1 || out_rd !== 5'd7) begin errors++; $display("[TB] FAIL lui_no_src got v=%0b we=%0b rd=%0d expected v=1 we=1 rd=7", out_valid, out_we, out_rd); end
        tick();
        drive(0, '0, '0, 0, 0, 0, 1);
        tick();
        drive(0, '0, '0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0 || stall_cnt !== 32'd1) begin errors++; $display("[TB] FAIL mid_stall got v=%0b stall=%0d expected v=0 stall=1", out_valid, stall_cnt); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_we !== 1'b0 || stall_cnt !== 32'd0) begin errors++; $display("[TB] FAIL async_reset got v=%0b rdy=%0b we=%0b stall=%0d expected 0 1 0 0", out_valid, in_ready, out_we, stall_cnt); end
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        drive(1, rs6, 32'h700, 0, 0, 0, 1);
        tick();
        drive(1, enc_r(5'd7, 5'd0, 5'd9, 6'b100001), 32'h704, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL reset_cleared6 got %0b expected 1", out_valid); end
        tick();
        drive(0, '0, '0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL reset_cleared7 got %0b expected 1", out_valid); end
        tick();
    endtask

    task automatic test_random();
        bit iv, fl, wv, ordy;
        logic [4:0] wr;
        logic [31:0] insn, pc;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            iv   = ($urandom_range(0, 9) < 7);
            insn = rand_insn();
            pc   = $urandom();
            fl   = ($urandom_range(0, 19) == 0);
            ordy = ($urandom_range(0, 4) != 0);
            wv   = 1'b0;
            wr   = '0;
            if (retire_q.size() > 0 && $urandom_range(0, 9) < 4) begin
                wv = 1'b1;
                wr = 5'(retire_q[$urandom_range(0, retire_q.size() - 1)]);
            end else if ($urandom_range(0, 29) == 0) begin
                wr = 5'($urandom_range(0, 7));
                if (m_pend[int'(wr)] == 0) wv = 1'b1;
            end
            drive(iv, insn, pc, fl, wv, wr, ordy);
            checks++; if (out_valid !== exp_out_valid) begin errors++; $display("[TB] FAIL rnd_out_valid cycle %0d got %0b expected %0b", c, out_valid, exp_out_valid); end
            checks++; if (in_ready !== exp_in_ready) begin errors++; $display("[TB] FAIL rnd_in_ready cycle %0d got %0b expected %0b", c, in_ready, exp_in_ready); end
            checks++; if (out_we !== exp_we) begin errors++; $display("[TB] FAIL rnd_out_we cycle %0d got %0b expected %0b", c, out_we, exp_we); end
            checks++; if (stall_cnt !== m_stall) begin errors++; $display("[TB] FAIL rnd_stall_cnt cycle %0d got %0d expected %0d", c, stall_cnt, m_stall); end
            if (exp_out_valid) begin
                checks++; if (out_insn !== m_insn || out_pc !== m_pc) begin errors++; $display("[TB] FAIL rnd_payload cycle %0d got %0h/%0h expected %0h/%0h", c, out_insn, out_pc, m_insn, m_pc); end
            end
            if (exp_we) begin
                checks++; if (out_rd !== 5'(exp_rd)) begin errors++; $display("[TB] FAIL rnd_out_rd cycle %0d got %0d expected %0d", c, out_rd, exp_rd); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_raw_hazard();
        test_saturation();
        test_same_cycle();
        test_flush();
        test_back_pressure();
        test_zero_reg();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_scoreboard.md
DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 SHALL have parameters: XLEN, default 32, instruction/PC width; NUM_REGS, default 32, architectural register count; RAW, default 5, register address width (clog2 NUM_REGS); PEND_W, default 2, per-register pending-write counter width.
REQ-002 SHALL have ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  decode slot can accept this cycle.
- in_insn  in  XLEN  instruction word.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  branch taken; kill decode slot.
- wb_valid  in  1  one issued register-writing instruction retires.
- wb_rd  in  RAW  its destination.
- out_valid  out  1  issued instruction valid toward execute.
- out_ready  in  1  execute accepts.
- out_insn  out  XLEN  issued instruction.
- out_pc  out  XLEN  issued PC.
- out_rd  out  RAW  resolved destination.
- out_we  out  1  issued instruction writes a register.
- stall_cnt  out  32  saturating count of hazard-stall cycles.

Function
REQ-003 SHALL hold one decode slot (valid, insn, pc); in_ready = !slot_valid || issue, where issue = slot_valid && !hazard && out_ready.
REQ-004 SHALL load the slot on in_valid && in_ready; on issue with no new load, the slot SHALL clear.
REQ-005 SHALL drive out_valid = slot_valid && !hazard (combinational), with out_insn/out_pc taken from the slot.
REQ-006 SHALL decode sources: rs = insn[25:21], rt = insn[20:16]. Both used for opcode 000000 (except JR funct 001000: rs only), 011100, 101011, 101000, 000100, 000101. Rs only for 000001, 100011, 100000, 100100, 000110, 000111, 001001, 001010, 001101. None for 000010, 000011, 001111.
REQ-007 SHALL decode destination:
- rd = insn[15:11] for 000000 (JR excluded) and 011100.
- rt for 100011, 100000, 100100, 001001, 001010, 001111, 001101.
- 31 for 000011 (JAL).
- out_we = 0 for all other opcodes; out_we is forced 0 when the resolved destination is 0.
REQ-008 SHALL keep a PEND_W-bit pending counter per register; register 0 SHALL never be pending.
REQ-009 SHALL assert hazard when any used source has a nonzero counter, or when out_we = 1 and the destination counter equals 2^PEND_W-1 (saturation).
REQ-010 SHALL increment the destination counter on issue with out_we = 1, and decrement the wb_rd counter on wb_valid; when both events hit the same register in one cycle, the counter SHALL be unchanged.
REQ-011 SHALL ignore wb_valid on a zero counter (no underflow) and for wb_rd = 0.
REQ-012 SHALL, on flush, clear the slot at the clock edge and suppress issue in that cycle; out_valid SHALL read 0 while flush is high; counters are unaffected except by a coincident wb_valid.
REQ-013 SHALL keep in_ready = 1 during flush only when the slot is empty; an instruction loaded in the flush cycle is discarded.
REQ-014 SHALL increment stall_cnt on every cycle with slot_valid && hazard && !flush, saturating at 0xFFFFFFFF.
REQ-015 SHALL count every issued writing instruction exactly once in wb_valid, including instructions later killed downstream (retirement contract).

Reset
REQ-016 SHALL, on reset assertion, immediately clear slot_valid, all pending counters and stall_cnt; out_valid = 0, in_ready = 1, out_we = 0. Reset mid-stall drops the held instruction.

Verification
REQ-017 Issue ADDIU $t0 (rt=8) then ADDU reading $8, with no wb -> second instruction held, out_valid=0, stall_cnt increments each cycle; wb_valid wb_rd=8 -> issues next cycle.
REQ-018 Three issues writing $5 with PEND_W=2, no wb -> counter[5]=3; a fourth $5 writer stalls until one wb_valid for 5.
REQ-019 Issue writing $9 in the same cycle as wb_valid wb_rd=9 with counter[9]=1 -> counter[9] stays 1.
REQ-020 Slot holds a stalled BEQ, flush=1 -> slot empty next cycle, out_valid=0, counters unchanged.
REQ-021 out_ready=0 with a valid hazard-free slot -> in_ready=0, slot stable; in_valid ignored.
REQ-022 Writes to $0 and J/LUI sources -> never stall, counter[0]=0 throughout; reset asserted mid-stall -> all counters 0 asynchronously.
